trap_ctrl: RTL and testbench

Machine-mode trap sequencer for the CSR file. It detects synchronous exceptions, pending interrupts and `mret`, and produces the `mcause`/`mepc`/`mbadaddr`/`mip` values the CSR file takes as inputs. It owns the CSR file's single write port (`write_en`/`csr_addr`/`data_in`), passing core writes through when idle and taking priority while it updates `mstatus`. It also issues the PC redirect to `mtvec` or `mepc`.

---
 rtl/csr_pkg.sv | 27 ++
 rtl/irq_prio.sv | 35 +++
 rtl/trap_ctrl.sv | 159 +++++++++++++++
 tb/tb_trap_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR-port addresses,
// interrupt cause codes, mstatus bit positions and the sequencer state type.
package csr_pkg;

    // CSR-port addresses are the CSR number shifted left by two
    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0C00;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0D04;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0D08;
    localparam logic [31:0] CSR_MTVEC   = 32'h0000_0C14;

    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_RET  = 2'd2,
        ST_JUMP = 2'd3
    } trap_state_t;

endpackage

// File: rtl/irq_prio.sv
// Fixed-priority interrupt selector: external (11) over software (3) over timer (7),
// gated by the global MIE bit.
module irq_prio
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] irq_vec,
    input  logic            mie_bit,
    output logic            pending,
    output logic [3:0]      code
);

    // Only the three machine-level sources exist; the remaining bits carry no meaning
    logic unused_irq_bits;
    assign unused_irq_bits = ^{irq_vec[XLEN-1:12], irq_vec[10:8], irq_vec[6:4], irq_vec[2:0]};

    always_comb begin
        pending = 1'b0;
        code    = 4'd0;
        if (mie_bit) begin
            if (irq_vec[11]) begin
                pending = 1'b1;
                code    = CAUSE_MEI;
            end else if (irq_vec[3]) begin
                pending = 1'b1;
                code    = CAUSE_MSI;
            end else if (irq_vec[7]) begin
                pending = 1'b1;
                code    = CAUSE_MTI;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accepts exceptions, interrupts and mret, owns the
// CSR write port while updating mstatus, and issues the PC redirect.
//
// state   | meaning
// IDLE    | core CSR writes pass through; events are accepted here
// SAVE    | trap entry: write mstatus (MPIE<-MIE, MIE<-0, MPP<-11)
// RET     | mret: write mstatus (MIE<-MPIE, MPIE<-1)
// JUMP    | one-cycle redirect to mtvec (trap) or mepc (mret)
module trap_ctrl
    import csr_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [31:0] MSTATUS_ADDR = 32'h0000_0C00
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            exc_valid,
    input  logic [3:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret,
    input  logic            instr_boundary,
    input  logic [XLEN-1:0] next_pc,
    input  logic            irq_ext,
    input  logic            irq_sw,
    input  logic            time_compare,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic            core_we,
    input  logic [XLEN-1:0] core_addr,
    input  logic [XLEN-1:0] core_wdata,
    output logic            write_en,
    output logic [XLEN-1:0] csr_addr,
    output logic [XLEN-1:0] data_in,
    output logic [XLEN-1:0] mip,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mbadaddr,
    output logic            busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    trap_state_t     state, state_nxt;
    logic [XLEN-1:0] mip_nxt;
    logic            irq_pending;
    logic [3:0]      irq_code;
    logic            take_exc, take_irq, take_mret;
    logic            ret_q;
    logic [XLEN-1:0] mstatus_save, mstatus_ret;
    logic [XLEN-1:0] tvec_base;

    always_comb begin
        mip_nxt     = '0;
        mip_nxt[11] = irq_ext;
        mip_nxt[7]  = time_compare;
        mip_nxt[3]  = irq_sw;
    end

    irq_prio #(.XLEN(XLEN)) u_irq_prio (
        .irq_vec (mip & mie),
        .mie_bit (mstatus[MSTATUS_MIE]),
        .pending (irq_pending),
        .code    (irq_code)
    );

    assign take_exc  = (state == ST_IDLE) && exc_valid;
    assign take_irq  = (state == ST_IDLE) && !exc_valid && irq_pending && instr_boundary;
    assign take_mret = (state == ST_IDLE) && !exc_valid && !(irq_pending && instr_boundary) && mret;

    always_comb begin
        mstatus_save                                = mstatus;
        mstatus_save[MSTATUS_MPIE]                  = mstatus[MSTATUS_MIE];
        mstatus_save[MSTATUS_MIE]                   = 1'b0;
        mstatus_save[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_ret                                 = mstatus;
        mstatus_ret[MSTATUS_MIE]                    = mstatus[MSTATUS_MPIE];
        mstatus_ret[MSTATUS_MPIE]                   = 1'b1;
    end

    assign tvec_base = {mtvec[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            mip      <= '0;
            mcause   <= '0;
            mepc     <= '0;
            mbadaddr <= '0;
            ret_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            mip   <= mip_nxt;
            if (take_exc) begin
                mcause   <= {{(XLEN-4){1'b0}}, exc_code};
                mepc     <= exc_pc;
                mbadaddr <= exc_tval;
                ret_q    <= 1'b0;
            end else if (take_irq) begin
                mcause   <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
                mepc     <= next_pc;
                mbadaddr <= '0;
                ret_q    <= 1'b0;
            end else if (take_mret) begin
                ret_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        busy           = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        write_en       = 1'b0;
        csr_addr       = core_addr;
        data_in        = core_wdata;
        case (state)
            ST_IDLE: begin
                busy     = 1'b0;
                write_en = core_we;
                if (take_exc || take_irq) begin
                    state_nxt = ST_SAVE;
                end else if (take_mret) begin
                    state_nxt = ST_RET;
                end
            end
            ST_SAVE: begin
                write_en  = 1'b1;
                csr_addr  = MSTATUS_ADDR;
                data_in   = mstatus_save;
                state_nxt = ST_JUMP;
            end
            ST_RET: begin
                write_en  = 1'b1;
                csr_addr  = MSTATUS_ADDR;
                data_in   = mstatus_ret;
                state_nxt = ST_JUMP;
            end
            ST_JUMP: begin
                redirect_valid = 1'b1;
                // Vectored mode offsets only interrupts, by 4 * cause code
                if (ret_q) begin
                    redirect_pc = mepc;
                end else if (mtvec[1:0] == 2'b01 && mcause[XLEN-1]) begin
                    redirect_pc = tvec_base + {{(XLEN-6){1'b0}}, mcause[3:0], 2'b00};
                end else begin
                    redirect_pc = tvec_base;
                end
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: reset passthrough, exception, interrupt priority
// and vectoring, gating, mret, event priority and reset abort.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc, exc_tval;
    logic        mret, instr_boundary;
    logic [31:0] next_pc;
    logic        irq_ext, irq_sw, time_compare;
    logic [31:0] mstatus, mie, mtvec;
    logic        core_we;
    logic [31:0] core_addr, core_wdata;
    logic        write_en;
    logic [31:0] csr_addr, data_in, mip, mcause, mepc, mbadaddr;
    logic        busy, redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .mret           (mret),
        .instr_boundary (instr_boundary),
        .next_pc        (next_pc),
        .irq_ext        (irq_ext),
        .irq_sw         (irq_sw),
        .time_compare   (time_compare),
        .mstatus        (mstatus),
        .mie            (mie),
        .mtvec          (mtvec),
        .core_we        (core_we),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .write_en       (write_en),
        .csr_addr       (csr_addr),
        .data_in        (data_in),
        .mip            (mip),
        .mcause         (mcause),
        .mepc           (mepc),
        .mbadaddr       (mbadaddr),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        exc_valid = 0; exc_code = 0; exc_pc = 0; exc_tval = 0;
        mret = 0; instr_boundary = 0; next_pc = 0;
        irq_ext = 0; irq_sw = 0; time_compare = 0;
        mstatus = 0; mie = 0; mtvec = 0;
        core_we = 1; core_addr = 32'hC00; core_wdata = 32'h8;
        #3;
        chk("rst_write_en", {31'b0, write_en}, 32'h1);
        chk("rst_csr_addr", csr_addr, 32'hC00);
        chk("rst_data_in", data_in, 32'h8);
        chk("rst_mip", mip, 32'h0);
        chk("rst_mcause", mcause, 32'h0);
        chk("rst_mepc", mepc, 32'h0);
        chk("rst_mbadaddr", mbadaddr, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_redirect", {31'b0, redirect_valid}, 32'h0);
        #4 resetn = 1'b1;
        tick();

        // Synchronous exception; core write in the same cycle is performed
        exc_valid = 1; exc_code = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
        mstatus = 32'h8; mtvec = 32'h400;
        core_we = 1; core_addr = 32'hD04; core_wdata = 32'h55;
        #1;
        chk("exc_core_we_pass", {31'b0, write_en}, 32'h1);
        chk("exc_core_data_pass", data_in, 32'h55);
        tick();
        exc_valid = 0;
        core_we = 1; core_addr = 32'h123; core_wdata = 32'h77;
        #1;
        chk("exc_mcause", mcause, 32'h2);
        chk("exc_mepc", mepc, 32'h100);
        chk("exc_mbadaddr", mbadaddr, 32'hDEAD);
        chk("exc_save_we", {31'b0, write_en}, 32'h1);
        chk("exc_save_addr", csr_addr, 32'hC00);
        chk("exc_save_data", data_in, 32'h1880);
        chk("exc_save_busy", {31'b0, busy}, 32'h1);
        chk("exc_save_noredir", {31'b0, redirect_valid}, 32'h0);
        mstatus = 32'h1880;
        tick();
        chk("exc_jump_valid", {31'b0, redirect_valid}, 32'h1);
        chk("exc_jump_pc", redirect_pc, 32'h400);
        chk("exc_jump_core_dropped", {31'b0, write_en}, 32'h0);
        tick();
        chk("exc_idle_busy", {31'b0, busy}, 32'h0);
        chk("exc_idle_redir", {31'b0, redirect_valid}, 32'h0);
        chk("exc_idle_pass", {31'b0, write_en}, 32'h1);
        core_we = 0;

        // All three sources pending but MIE=0, then boundary low: no trap
        irq_ext = 1; irq_sw = 1; time_compare = 1; mie = 32'h888;
        mstatus = 32'h0; instr_boundary = 1; next_pc = 32'h204;
        tick();
        chk("mip_sampled", mip, 32'h888);
        tick();
        chk("nomie_busy", {31'b0, busy}, 32'h0);
        mstatus = 32'h8; instr_boundary = 0;
        tick();
        chk("nobound_busy", {31'b0, busy}, 32'h0);
        chk("nobound_mcause", mcause, 32'h2);

        // Interrupt at a boundary, vectored mtvec, external wins priority
        instr_boundary = 1; mtvec = 32'h401;
        tick();
        irq_ext = 0; instr_boundary = 0;
        #1;
        chk("irq_mcause", mcause, 32'h8000000B);
        chk("irq_mepc", mepc, 32'h204);
        chk("irq_mbadaddr", mbadaddr, 32'h0);
        chk("irq_save_data", data_in, 32'h1880);
        mstatus = 32'h1880;
        tick();
        chk("irq_jump_valid", {31'b0, redirect_valid}, 32'h1);
        chk("irq_jump_pc", redirect_pc, 32'h42C);
        tick();
        chk("irq_idle_busy", {31'b0, busy}, 32'h0);
        chk("irq_mip_drop", mip, 32'h088);

        // Exception, mret and pending interrupt together: exception wins
        irq_ext = 1; mstatus = 32'h8;
        tick();
        exc_valid = 1; exc_code = 4'd5; exc_pc = 32'h104; exc_tval = 32'h44;
        mret = 1; instr_boundary = 1;
        tick();
        exc_valid = 0; mret = 0; instr_boundary = 0;
        irq_ext = 0; irq_sw = 0; time_compare = 0; mie = 0;
        #1;
        chk("prio_mcause", mcause, 32'h5);
        chk("prio_mepc", mepc, 32'h104);
        chk("prio_save_data", data_in, 32'h1880);
        mstatus = 32'h1880;
        tick();
        chk("prio_jump_pc", redirect_pc, 32'h400);
        tick();

        // mret returns to mepc
        mret = 1;
        tick();
        mret = 0;
        #1;
        chk("mret_we", {31'b0, write_en}, 32'h1);
        chk("mret_data", data_in, 32'h1888);
        chk("mret_busy", {31'b0, busy}, 32'h1);
        mstatus = 32'h1888;
        tick();
        chk("mret_jump_valid", {31'b0, redirect_valid}, 32'h1);
        chk("mret_jump_pc", redirect_pc, 32'h104);
        tick();
        chk("mret_idle_busy", {31'b0, busy}, 32'h0);

        // Reset during SAVE aborts without redirect
        mstatus = 32'h0;
        exc_valid = 1; exc_code = 4'd1; exc_pc = 32'h300; exc_tval = 32'h0;
        tick();
        exc_valid = 0;
        chk("abort_in_save", {31'b0, busy}, 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_mcause", mcause, 32'h0);
        chk("abort_redir", {31'b0, redirect_valid}, 32'h0);
        resetn = 1'b1;
        tick();
        chk("abort_noredir1", {31'b0, redirect_valid}, 32'h0);
        chk("abort_idle1", {31'b0, busy}, 32'h0);
        tick();
        chk("abort_noredir2", {31'b0, redirect_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
